io_write_port_bank: RTL and testbench
=====================================

IO_WRITE_PORT_BANK -- requirements
Module: io_write_port_bank

Interface
REQ-001 The block SHALL have parameter PORT_COUNT, default 4: number of write ports, equal to the decoder OUTPUT_WIDTH.
REQ-002 The block SHALL have parameter WORD_WIDTH, default 36: data width per port.
REQ-003 The block SHALL have port clock, input, 1: the single clock, all state on rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port wren, input, 1: write strobe qualifying the current instruction's write.
REQ-006 The block SHALL have port port_select, input, PORT_COUNT: one-hot port select from the address decoder; all-zero means no port addressed.
REQ-007 The block SHALL have port write_data, input, WORD_WIDTH: data to be written.
REQ-008 The block SHALL have port port_data, output, PORT_COUNT*WORD_WIDTH: registered data, port i at bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-009 The block SHALL have port port_valid, output, PORT_COUNT: per-port data-valid to the external consumer.
REQ-010 The block SHALL have port port_ready, input, PORT_COUNT: per-port consumer ready.
REQ-011 The block SHALL have port write_stall, output, 1: the current write targets a full, non-draining port and was not accepted.
REQ-012 The block SHALL have port select_error, output, 1: registered one-cycle pulse flagging a multi-hot port_select on a write.

Function
REQ-013 Each port SHALL hold a two-state machine, EMPTY and FULL; port_valid[i] SHALL be 1 exactly when port i is FULL.
REQ-014 A write to port i SHALL be accepted when wren=1, port_select[i]=1, port_select has exactly one bit set, and port i is EMPTY or (FULL and port_ready[i]=1).
REQ-015 An accepted write SHALL load write_data into port i's register and leave port i FULL on the next edge; data is visible on port_data one cycle after acceptance.
REQ-016 A transfer on port i SHALL occur when FULL and port_ready[i]=1; without a simultaneous accepted write, port i SHALL go EMPTY on the next edge.
REQ-017 A simultaneous transfer and accepted write on the same port SHALL leave it FULL with the new data; there is no bubble cycle.
REQ-018 port_data[i] SHALL hold its value while FULL and not transferring, and SHALL be ignored while EMPTY (it retains its last value).
REQ-019 write_stall SHALL be combinational: it is 1 when wren=1, port_select is one-hot, and the selected port is FULL with port_ready=0; the write SHALL be dropped and the issuer SHALL replay it.
REQ-020 An all-zero port_select with wren=1 SHALL write nothing, raise no stall and raise no error (the address is out of range).
REQ-021 A port_select with two or more bits set and wren=1 SHALL write nothing and raise no stall, and select_error SHALL be 1 on the following cycle only.
REQ-022 port_ready[i] while EMPTY SHALL have no effect.

Reset
REQ-023 Asserting reset SHALL immediately force all ports EMPTY, port_valid to 0, port_data to 0 and select_error to 0, independent of clock.
REQ-024 A write or transfer coincident with the reset-release edge SHALL be ignored; the first write accepted is the one on the first edge after release.
REQ-025 Reset asserted mid-operation SHALL discard held data without performing a transfer.

Structure
REQ-026 The EMPTY/FULL state encoding SHALL be defined in a shared package, io_port_pkg, together with a one-hot check function.
REQ-027 One sub-module, io_write_port, SHALL implement a single port's register, FSM and handshake, and SHALL be instantiated PORT_COUNT times.
REQ-028 The one-hot check, write_stall and select_error logic SHALL live in the top level.

Verification (PORT_COUNT=4, WORD_WIDTH=8)
REQ-029 Reset, then wren=1, port_select=0100, write_data=0xA5 -> next cycle port_valid=0100, port 2 data 0xA5, write_stall=0.
REQ-030 Port 2 FULL, port_ready=0000, write 0x3C to port 2 -> write_stall=1 that cycle, port 2 data stays 0xA5.
REQ-031 Port 2 FULL, port_ready[2]=1 with a write of 0x3C to port 2 in the same cycle -> port_valid[2] stays 1, data 0x3C, no stall.
REQ-032 wren=1, port_select=0011, data 0xFF -> no port changes, select_error=1 for exactly one cycle; port_select=0000 -> nothing changes, no flags.
REQ-033 Ports 0 and 3 FULL, assert reset between clock edges -> port_valid=0000 and port_data=0 before the next edge; after release, a write to port 3 with 0x11 -> port_valid=1000.
REQ-034 Port 1 FULL, port_ready[1]=1 for one cycle with no write -> port_valid[1] falls next cycle; a later port_ready[1] pulse -> no change.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared definitions for the write-port bank: per-port state encoding and
// the one-hot test used to validate the decoder's port select.
package io_port_pkg;

    localparam int MAX_PORTS = 32;

    typedef enum logic {
        PORT_EMPTY = 1'b0,
        PORT_FULL  = 1'b1
    } port_state_t;

    // Narrower selects are zero-extended by the caller.
    function automatic logic is_onehot(input logic [MAX_PORTS-1:0] i_vec);
        return (i_vec != '0) && ((i_vec & (i_vec - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/io_write_port.sv
// One write port: a single-entry holding register with an EMPTY/FULL state
// and a valid/ready handshake toward the external consumer.
module io_write_port
    import io_port_pkg::*;
#(
    parameter int WORD_WIDTH = 36
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_wr_req,
    input  logic [WORD_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic [WORD_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_stall
);

    port_state_t           r_state;
    logic [WORD_WIDTH-1:0] r_data;
    logic                  w_full;
    logic                  w_accept;
    logic                  w_xfer;

    assign w_full   = (r_state == PORT_FULL);
    assign w_xfer   = w_full && i_ready;
    // A full port still accepts when it drains in the same cycle, so no bubble.
    assign w_accept = i_wr_req && (!w_full || i_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= PORT_EMPTY;
            r_data  <= '0;
        end else begin
            case (r_state)
                PORT_EMPTY: begin
                    if (w_accept) begin
                        r_state <= PORT_FULL;
                        r_data  <= i_data;
                    end
                end
                PORT_FULL: begin
                    if (w_accept) begin
                        r_data <= i_data;
                    end else if (w_xfer) begin
                        r_state <= PORT_EMPTY;
                    end
                end
                default: r_state <= PORT_EMPTY;
            endcase
        end
    end

    assign o_data  = r_data;
    assign o_valid = w_full;
    assign o_stall = i_wr_req && w_full && !i_ready;

endmodule

// File: rtl/io_write_port_bank.sv
// Bank of PORT_COUNT independent write ports fed by a one-hot address decoder;
// flags stalled writes and multi-hot selects.
module io_write_port_bank
    import io_port_pkg::*;
#(
    parameter int PORT_COUNT = 4,
    parameter int WORD_WIDTH = 36
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             wren,
    input  logic [PORT_COUNT-1:0]            port_select,
    input  logic [WORD_WIDTH-1:0]            write_data,
    output logic [PORT_COUNT*WORD_WIDTH-1:0] port_data,
    output logic [PORT_COUNT-1:0]            port_valid,
    input  logic [PORT_COUNT-1:0]            port_ready,
    output logic                             write_stall,
    output logic                             select_error
);

    logic                  w_onehot;
    logic                  w_multi_hot;
    logic [PORT_COUNT-1:0] w_wr_req;
    logic [PORT_COUNT-1:0] w_stall;
    logic                  r_select_error;

    assign w_onehot    = is_onehot(MAX_PORTS'(port_select));
    // All-zero select is an out-of-range address, not an error.
    assign w_multi_hot = wren && (port_select != '0) && !w_onehot;
    assign w_wr_req    = {PORT_COUNT{wren && w_onehot}} & port_select;

    for (genvar g = 0; g < PORT_COUNT; g++) begin : g_port
        io_write_port #(
            .WORD_WIDTH(WORD_WIDTH)
        ) u_port (
            .clock    (clock),
            .reset    (reset),
            .i_wr_req (w_wr_req[g]),
            .i_data   (write_data),
            .i_ready  (port_ready[g]),
            .o_data   (port_data[g*WORD_WIDTH +: WORD_WIDTH]),
            .o_valid  (port_valid[g]),
            .o_stall  (w_stall[g])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_select_error <= 1'b0;
        end else begin
            r_select_error <= w_multi_hot;
        end
    end

    assign write_stall  = |w_stall;
    assign select_error = r_select_error;

endmodule

// File: tb/tb_io_write_port_bank.sv
// Directed, table-driven bench for io_write_port_bank (4 ports x 8 bits).
module tb_io_write_port_bank;

    localparam int PC = 4;
    localparam int WW = 8;

    logic              clock;
    logic              reset;
    logic              wren;
    logic [PC-1:0]     port_select;
    logic [WW-1:0]     write_data;
    logic [PC*WW-1:0]  port_data;
    logic [PC-1:0]     port_valid;
    logic [PC-1:0]     port_ready;
    logic              write_stall;
    logic              select_error;

    int n_checks = 0;
    int n_fails  = 0;

    io_write_port_bank #(
        .PORT_COUNT(PC),
        .WORD_WIDTH(WW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wren         (wren),
        .port_select  (port_select),
        .write_data   (write_data),
        .port_data    (port_data),
        .port_valid   (port_valid),
        .port_ready   (port_ready),
        .write_stall  (write_stall),
        .select_error (select_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic          wren;
        logic [PC-1:0] sel;
        logic [WW-1:0] data;
        logic [PC-1:0] rdy;
        logic          exp_stall;
        logic [PC-1:0] exp_valid;
        logic [31:0]   exp_data;
        logic          exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clock);
        wren        = v.wren;
        port_select = v.sel;
        write_data  = v.data;
        port_ready  = v.rdy;
        #1;
        check($sformatf("v%0d stall", idx), 32'(write_stall), 32'(v.exp_stall));
        @(posedge clock);
        #1;
        check($sformatf("v%0d valid", idx), 32'(port_valid), 32'(v.exp_valid));
        check($sformatf("v%0d data", idx), port_data, v.exp_data);
        check($sformatf("v%0d selerr", idx), 32'(select_error), 32'(v.exp_err));
    endtask

    initial begin
        //           wren sel      data   rdy      stall valid    data          err
        vecs[0]  = '{1'b1, 4'b0100, 8'hA5, 4'b0000, 1'b0, 4'b0100, 32'h00A50000, 1'b0};
        vecs[1]  = '{1'b1, 4'b0100, 8'h3C, 4'b0000, 1'b1, 4'b0100, 32'h00A50000, 1'b0};
        vecs[2]  = '{1'b1, 4'b0100, 8'h3C, 4'b0100, 1'b0, 4'b0100, 32'h003C0000, 1'b0};
        vecs[3]  = '{1'b1, 4'b0011, 8'hFF, 4'b0000, 1'b0, 4'b0100, 32'h003C0000, 1'b1};
        vecs[4]  = '{1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0, 4'b0100, 32'h003C0000, 1'b0};
        vecs[5]  = '{1'b1, 4'b0000, 8'hFF, 4'b0000, 1'b0, 4'b0100, 32'h003C0000, 1'b0};
        vecs[6]  = '{1'b1, 4'b0010, 8'h77, 4'b0000, 1'b0, 4'b0110, 32'h003C7700, 1'b0};
        vecs[7]  = '{1'b0, 4'b0000, 8'h00, 4'b0010, 1'b0, 4'b0100, 32'h003C7700, 1'b0};
        vecs[8]  = '{1'b0, 4'b0000, 8'h00, 4'b0010, 1'b0, 4'b0100, 32'h003C7700, 1'b0};
        vecs[9]  = '{1'b1, 4'b0001, 8'h12, 4'b0100, 1'b0, 4'b0001, 32'h003C7712, 1'b0};
        vecs[10] = '{1'b1, 4'b1111, 8'h99, 4'b0000, 1'b0, 4'b0001, 32'h003C7712, 1'b1};
        vecs[11] = '{1'b1, 4'b1000, 8'h55, 4'b0000, 1'b0, 4'b1001, 32'h553C7712, 1'b0};
        vecs[12] = '{1'b0, 4'b1000, 8'hEE, 4'b0000, 1'b0, 4'b1001, 32'h553C7712, 1'b0};

        reset       = 1'b1;
        wren        = 1'b0;
        port_select = '0;
        write_data  = '0;
        port_ready  = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset valid", 32'(port_valid), 32'h0);
        check("reset data", port_data, 32'h0);
        check("reset selerr", 32'(select_error), 32'h0);
        check("reset stall", 32'(write_stall), 32'h0);

        for (int i = 0; i < 13; i++) apply(vecs[i], i);

        // Raise select_error, then assert reset between edges: everything clears at once.
        @(negedge clock);
        wren        = 1'b1;
        port_select = 4'b0011;
        write_data  = 8'hFF;
        port_ready  = '0;
        @(posedge clock);
        #1;
        check("pre-reset selerr", 32'(select_error), 32'h1);
        check("pre-reset valid", 32'(port_valid), 32'h9);
        #2;
        reset = 1'b1;
        #1;
        check("async reset valid", 32'(port_valid), 32'h0);
        check("async reset data", port_data, 32'h0);
        check("async reset selerr", 32'(select_error), 32'h0);

        // Write held during reset must not land; first write after release does.
        port_select = 4'b1000;
        write_data  = 8'h11;
        @(posedge clock);
        #1;
        check("held-in-reset valid", 32'(port_valid), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("post-reset valid", 32'(port_valid), 32'h8);
        check("post-reset data", port_data, 32'h11000000);

        // Single-cycle drain of a lone full port, then a ready pulse while empty.
        @(negedge clock);
        wren       = 1'b0;
        port_ready = 4'b1000;
        @(posedge clock);
        #1;
        check("drain valid", 32'(port_valid), 32'h0);
        @(negedge clock);
        port_ready = 4'b0000;
        @(posedge clock);
        #1;
        check("idle valid", 32'(port_valid), 32'h0);
        check("retained data", port_data, 32'h11000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
